// File: rtl/seg_scan_ctrl.sv
// Scan scheduler for an 8-digit multiplexed 7-segment display with a double-buffered digit store.
// Define SEG_SCAN_LZB_EN to build leading-zero blanking of the active digit set.
module seg_scan_ctrl #(
  parameter int TICK_DIV = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [2:0] wr_addr,
  input  logic [3:0] wr_data,
  input  logic       commit,
  output logic       commit_pending,
  input  logic [7:0] dig_en,
  input  logic [2:0] bright,
  output logic [6:0] seg,
  output logic [7:0] an,
  output logic       frame_done
);

  localparam int            CW      = $clog2(TICK_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_PRE = CW'(TICK_DIV - 2);
  localparam logic [CW-1:0] SUB_W   = CW'(TICK_DIV / 8);

  typedef enum logic [1:0] {
    PH_GUARD = 2'd0,
    PH_ON    = 2'd1,
    PH_OFF   = 2'd2
  } phase_t;

  function automatic logic [6:0] seg_enc(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

`ifdef SEG_SCAN_LZB_EN
  // Blank from digit 7 downward while zero; digit 0 always survives.
  function automatic logic [7:0] lzb_mask(input logic [7:0][3:0] d);
    logic [7:0] m;
    logic       lead;
    m    = 8'h00;
    lead = 1'b1;
    for (int i = 7; i >= 1; i--) begin
      if (lead && (d[i] == 4'h0)) begin
        m[i] = 1'b1;
      end else begin
        lead = 1'b0;
      end
    end
    return m;
  endfunction
`endif

  logic [CW-1:0]   cnt_r;
  logic [2:0]      slot_r;
  phase_t          phase_r;
  logic [CW-1:0]   on_end_r;
  logic [7:0][3:0] shadow_r;
  logic [7:0][3:0] active_r;
  logic            pending_r;
  logic            wr_ready_r;
  logic [6:0]      seg_r;
  logic [7:0]      an_r;
  logic            frame_done_r;
`ifdef SEG_SCAN_LZB_EN
  logic [7:0]      blank_r;
`endif

  logic            wrap_s;
  logic            boundary_s;
  logic            pre_boundary_s;
  logic            wr_fire_s;
  logic [7:0]      an_on_s;
  logic [6:0]      digit_seg_s;

  // Decode counter position and the values the output stage may load.
  always_comb begin
    wrap_s         = (cnt_r == CNT_MAX);
    boundary_s     = wrap_s && (slot_r == 3'd7);
    pre_boundary_s = (cnt_r == CNT_PRE) && (slot_r == 3'd7);
    wr_fire_s      = wr_valid && wr_ready_r;
    if (dig_en[slot_r]) begin
      an_on_s = ~(8'd1 << slot_r);
    end else begin
      an_on_s = 8'hFF;
    end
`ifdef SEG_SCAN_LZB_EN
    if (blank_r[slot_r]) begin
      digit_seg_s = 7'b1111111;
    end else begin
      digit_seg_s = seg_enc(active_r[slot_r]);
    end
`else
    digit_seg_s = seg_enc(active_r[slot_r]);
`endif
  end

  // Slot counter and per-slot GUARD/ON/OFF phase machine.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r   <= {CW{1'b0}};
      slot_r  <= 3'd0;
      phase_r <= PH_GUARD;
    end else if (wrap_s) begin
      cnt_r   <= {CW{1'b0}};
      slot_r  <= slot_r + 3'd1;
      phase_r <= PH_GUARD;
    end else begin
      cnt_r <= cnt_r + CW'(1);
      case (phase_r)
        PH_GUARD: phase_r <= PH_ON;
        PH_ON:    phase_r <= (cnt_r == on_end_r) ? PH_OFF : PH_ON;
        PH_OFF:   phase_r <= PH_OFF;
        default:  phase_r <= PH_GUARD;
      endcase
    end
  end

  // Registered display outputs; frame_done/wr_ready use lookahead so they align with the copy cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_r        <= 7'b1111111;
      an_r         <= 8'hFF;
      on_end_r     <= CNT_MAX;
      frame_done_r <= 1'b0;
      wr_ready_r   <= 1'b1;
    end else begin
      case (phase_r)
        PH_GUARD: begin
          an_r     <= 8'hFF;
          seg_r    <= digit_seg_s;
          on_end_r <= CW'(bright) * SUB_W + (SUB_W - CW'(1));
        end
        PH_ON:   an_r <= an_on_s;
        PH_OFF:  an_r <= 8'hFF;
        default: an_r <= 8'hFF;
      endcase
      frame_done_r <= pre_boundary_s;
      wr_ready_r   <= ~pre_boundary_s;
    end
  end

  // Shadow writes, commit tracking and the frame-boundary promotion to the active set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_r  <= {8{4'hF}};
      active_r  <= {8{4'hF}};
      pending_r <= 1'b0;
`ifdef SEG_SCAN_LZB_EN
      blank_r   <= 8'h00;
`endif
    end else begin
      if (wr_fire_s) begin
        shadow_r[wr_addr] <= wr_data;
      end
      if (boundary_s && pending_r) begin
        active_r <= shadow_r;
`ifdef SEG_SCAN_LZB_EN
        blank_r  <= lzb_mask(shadow_r);
`endif
      end
      if (commit) begin
        pending_r <= 1'b1;
      end else if (boundary_s) begin
        pending_r <= 1'b0;
      end
    end
  end

  assign seg            = seg_r;
  assign an             = an_r;
  assign frame_done     = frame_done_r;
  assign wr_ready       = wr_ready_r;
  assign commit_pending = pending_r;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed self-checking bench for seg_scan_ctrl with TICK_DIV=16 (SUB=2, 128-cycle frame).
module tb_seg_scan_ctrl;

  logic       clk;
  logic       rst_n;
  logic       wr_valid;
  logic       wr_ready;
  logic [2:0] wr_addr;
  logic [3:0] wr_data;
  logic       commit;
  logic       commit_pending;
  logic [7:0] dig_en;
  logic [2:0] bright;
  logic [6:0] seg;
  logic [7:0] an;
  logic       frame_done;

  int vec_cnt = 0;
  int err_cnt = 0;
  int cyc;

  seg_scan_ctrl #(.TICK_DIV(16)) dut (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .commit(commit),
    .commit_pending(commit_pending), .dig_en(dig_en), .bright(bright),
    .seg(seg), .an(an), .frame_done(frame_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle index since reset release; cycle k is sampled at the k-th falling edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  task automatic wait_cyc(input int k);
    while (cyc < k) @(negedge clk);
  endtask

  // Expected anode pattern for cycle k, assuming a constant on-window end within the range.
  function automatic logic [7:0] exp_an(input int k, input int on_end, input logic [7:0] en);
    int j, c, s;
    if (k <= 0) return 8'hFF;
    j = k - 1;
    c = j % 16;
    s = (j / 16) % 8;
    if (c == 0 || c > on_end || !en[s]) return 8'hFF;
    return ~(8'h01 << s);
  endfunction

  task automatic do_write(input logic [2:0] a, input logic [3:0] d);
    wr_valid = 1'b1; wr_addr = a; wr_data = d;
    vec_cnt++;
    if (wr_ready !== 1'b1) begin
      err_cnt++;
      $display("FAIL wr_ready_idle cyc=%0d got=%b exp=1", cyc, wr_ready);
    end
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    vec_cnt++;
    if ({an, seg, wr_ready, commit_pending, frame_done} !== {8'hFF, 7'h7F, 1'b1, 1'b0, 1'b0}) begin
      err_cnt++;
      $display("FAIL reset_hold got=%h/%h/%b%b%b exp=ff/7f/100", an, seg, wr_ready, commit_pending, frame_done);
    end
    rst_n = 1'b1;
    vec_cnt++;
    if ({an, seg, wr_ready, commit_pending, frame_done} !== {8'hFF, 7'h7F, 1'b1, 1'b0, 1'b0}) begin
      err_cnt++;
      $display("FAIL reset_release got=%h/%h/%b%b%b exp=ff/7f/100", an, seg, wr_ready, commit_pending, frame_done);
    end
  endtask

  task automatic test_blank_frame;
    for (int k = 0; k <= 128; k++) begin
      wait_cyc(k);
      vec_cnt++;
      if (an !== exp_an(k, 15, 8'hFF)) begin
        err_cnt++;
        $display("FAIL blank_an cyc=%0d got=%h exp=%h", k, an, exp_an(k, 15, 8'hFF));
      end
      vec_cnt++;
      if (seg !== 7'h7F) begin
        err_cnt++;
        $display("FAIL blank_seg cyc=%0d got=%h exp=7f", k, seg);
      end
      vec_cnt++;
      if (frame_done !== (k == 127)) begin
        err_cnt++;
        $display("FAIL frame_done cyc=%0d got=%b exp=%b", k, frame_done, (k == 127));
      end
    end
  endtask

  task automatic test_commit;
    wait_cyc(130); do_write(3'd0, 4'd5);
    do_write(3'd1, 4'd2);
    vec_cnt++;
    if (commit_pending !== 1'b0) begin
      err_cnt++; $display("FAIL pend_before cyc=%0d got=%b exp=0", cyc, commit_pending);
    end
    commit = 1'b1; @(negedge clk); commit = 1'b0;
    vec_cnt++;
    if (commit_pending !== 1'b1) begin
      err_cnt++; $display("FAIL pend_set cyc=%0d got=%b exp=1", cyc, commit_pending);
    end
    wait_cyc(140); commit = 1'b1; @(negedge clk); commit = 1'b0;
    wait_cyc(146);
    vec_cnt++;
    if (seg !== 7'h7F) begin
      err_cnt++; $display("FAIL no_tear cyc=%0d got=%h exp=7f", cyc, seg);
    end
    wait_cyc(254);
    vec_cnt++;
    if ({wr_ready, commit_pending, frame_done} !== 3'b110) begin
      err_cnt++; $display("FAIL pre_copy cyc=%0d got=%b exp=110", cyc, {wr_ready, commit_pending, frame_done});
    end
    wait_cyc(255);
    vec_cnt++;
    if ({wr_ready, commit_pending, frame_done} !== 3'b011) begin
      err_cnt++; $display("FAIL copy_cycle cyc=%0d got=%b exp=011", cyc, {wr_ready, commit_pending, frame_done});
    end
    wait_cyc(256);
    vec_cnt++;
    if ({wr_ready, commit_pending, frame_done} !== 3'b100) begin
      err_cnt++; $display("FAIL post_copy cyc=%0d got=%b exp=100", cyc, {wr_ready, commit_pending, frame_done});
    end
    wait_cyc(258);
    vec_cnt++;
    if ({an, seg} !== {8'hFE, 7'h12}) begin
      err_cnt++; $display("FAIL slot0_five cyc=%0d got=%h/%h exp=fe/12", cyc, an, seg);
    end
    wait_cyc(274);
    vec_cnt++;
    if ({an, seg} !== {8'hFD, 7'h24}) begin
      err_cnt++; $display("FAIL slot1_two cyc=%0d got=%h/%h exp=fd/24", cyc, an, seg);
    end
    wait_cyc(290);
    vec_cnt++;
    if (seg !== 7'h7F) begin
      err_cnt++; $display("FAIL slot2_blank cyc=%0d got=%h exp=7f", cyc, seg);
    end
    wait_cyc(300); commit = 1'b1; @(negedge clk); commit = 1'b0;
    wait_cyc(383);
    vec_cnt++;
    if ({wr_ready, commit_pending} !== 2'b01) begin
      err_cnt++; $display("FAIL copy2_cycle cyc=%0d got=%b exp=01", cyc, {wr_ready, commit_pending});
    end
    commit = 1'b1; @(negedge clk); commit = 1'b0;
    vec_cnt++;
    if (commit_pending !== 1'b1) begin
      err_cnt++; $display("FAIL commit_on_copy cyc=%0d got=%b exp=1", cyc, commit_pending);
    end
    wait_cyc(512);
    vec_cnt++;
    if (commit_pending !== 1'b0) begin
      err_cnt++; $display("FAIL pend_clear cyc=%0d got=%b exp=0", cyc, commit_pending);
    end
  endtask

  task automatic test_bright;
    int on_end;
    wait_cyc(520); bright = 3'd1;
    for (int k = 521; k <= 560; k++) begin
      wait_cyc(k);
      if (k == 540) bright = 3'd7;
      on_end = (k <= 528 || k >= 545) ? 15 : 3;
      vec_cnt++;
      if (an !== exp_an(k, on_end, 8'hFF)) begin
        err_cnt++;
        $display("FAIL bright_an cyc=%0d got=%h exp=%h", k, an, exp_an(k, on_end, 8'hFF));
      end
    end
  endtask

  task automatic test_dig_en;
    wait_cyc(635); dig_en = 8'b0000_0101;
    for (int k = 637; k <= 768; k++) begin
      wait_cyc(k);
      vec_cnt++;
      if (an !== exp_an(k, 15, 8'h05)) begin
        err_cnt++;
        $display("FAIL dig_en_an cyc=%0d got=%h exp=%h", k, an, exp_an(k, 15, 8'h05));
      end
      vec_cnt++;
      if (frame_done !== ((k % 128) == 127)) begin
        err_cnt++;
        $display("FAIL dig_en_period cyc=%0d got=%b exp=%b", k, frame_done, ((k % 128) == 127));
      end
    end
    wait_cyc(769); dig_en = 8'hFF;
  endtask

  task automatic test_reset_midframe;
    wait_cyc(839);
    vec_cnt++;
    if (an !== 8'hEF) begin
      err_cnt++; $display("FAIL pre_reset_an cyc=%0d got=%h exp=ef", cyc, an);
    end
    rst_n = 1'b0;
    #1;
    vec_cnt++;
    if ({an, seg, commit_pending, frame_done} !== {8'hFF, 7'h7F, 1'b0, 1'b0}) begin
      err_cnt++; $display("FAIL async_reset got=%h/%h/%b%b exp=ff/7f/00", an, seg, commit_pending, frame_done);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k <= 18; k++) begin
      wait_cyc(k);
      vec_cnt++;
      if (an !== exp_an(k, 15, 8'hFF)) begin
        err_cnt++;
        $display("FAIL restart_an cyc=%0d got=%h exp=%h", k, an, exp_an(k, 15, 8'hFF));
      end
    end
    vec_cnt++;
    if (seg !== 7'h7F) begin
      err_cnt++; $display("FAIL restart_seg cyc=%0d got=%h exp=7f", cyc, seg);
    end
  endtask

  task automatic test_lzb;
    logic [6:0] exp_seg;
    for (int i = 0; i < 8; i++) begin
      wait_cyc(20 + i);
      do_write(3'(i), (i == 2) ? 4'd1 : 4'd0);
    end
    wait_cyc(28); commit = 1'b1; @(negedge clk); commit = 1'b0;
    for (int s = 0; s < 8; s++) begin
      wait_cyc(128 + 16 * s + 2);
      if (s == 2) exp_seg = 7'h79;
      else if (s < 2) exp_seg = 7'h40;
`ifdef SEG_SCAN_LZB_EN
      else exp_seg = 7'h7F;
`else
      else exp_seg = 7'h40;
`endif
      vec_cnt++;
      if ({an, seg} !== {~(8'h01 << s), exp_seg}) begin
        err_cnt++;
        $display("FAIL lzb_slot%0d cyc=%0d got=%h/%h exp=%h/%h", s, cyc, an, seg, ~(8'h01 << s), exp_seg);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; wr_valid = 1'b0; wr_addr = 3'd0; wr_data = 4'd0;
    commit = 1'b0; dig_en = 8'hFF; bright = 3'd7;
    test_reset;
    test_blank_frame;
    test_commit;
    test_bright;
    test_dig_en;
    test_reset_midframe;
    test_lzb;
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
